pcie_arbitro_tx: RTL and testbench

Transmit-side merger for the PCIE block. It drains the four per-class output FIFOs (classes 4..7) with a round-robin arbiter and pushes one re-tagged 12-bit word per cycle into a single downstream egress FIFO. The class tag is rebuilt in bits [11:10] so the receive-side demux can split the stream again. It also holds the control FSM (RESET/INIT/IDLE/ACTIVE/ERROR), latches the FIFO thresholds during INIT, and keeps per-class word counters that are read through the req/idx port.

---
 rtl/pcie_arbitro_tx.sv | 170 +++++++++++++++++
 tb/tb_pcie_arbitro_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_arbitro_tx.sv
// rtl/pcie_arbitro_tx.sv - round-robin merger of class FIFOs 4..7 into one re-tagged egress stream
module pcie_arbitro_tx #(
  parameter int TAMANO_DATOS = 12,
  parameter int UMBRALES_L_H = 8,
  parameter int CNT_W        = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRALES_L_H-1:0] umbral_L,
  input  logic [UMBRALES_L_H-1:0] umbral_H,
  input  logic [TAMANO_DATOS-1:0] data_in4,
  input  logic [TAMANO_DATOS-1:0] data_in5,
  input  logic [TAMANO_DATOS-1:0] data_in6,
  input  logic [TAMANO_DATOS-1:0] data_in7,
  input  logic [3:0]              empty,
  input  logic                    almost_full_out,
  input  logic                    full_out,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [3:0]              pop,
  output logic                    push,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic [UMBRALES_L_H-1:0] umbral_L_out,
  output logic [UMBRALES_L_H-1:0] umbral_H_out,
  output logic [2:0]              estado,
  output logic                    error_out,
  output logic [CNT_W-1:0]        contador,
  output logic                    valid_contador
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                  state;
  logic [1:0]              rr_ptr;
  logic [1:0]              push_idx;
  logic [1:0]              grant_idx;
  logic [1:0]              cand;
  logic                    grant_found;
  logic                    pop_en;
  logic                    overflow;
  logic [TAMANO_DATOS-3:0] data_sel;
  logic [TAMANO_DATOS-1:0] fresh_word;
  logic [TAMANO_DATOS-1:0] data_hold;
  logic [CNT_W-1:0]        cnt [4];
  logic [CNT_W-1:0]        cnt_total;
  logic                    unused_tags;

  // The incoming tag bits are discarded; the tag is rebuilt from the grant index.
  assign unused_tags = ^{data_in4[TAMANO_DATOS-1:TAMANO_DATOS-2], data_in5[TAMANO_DATOS-1:TAMANO_DATOS-2],
                         data_in6[TAMANO_DATOS-1:TAMANO_DATOS-2], data_in7[TAMANO_DATOS-1:TAMANO_DATOS-2]};

  assign estado   = state;
  assign overflow = push & full_out;

  // Round-robin scan: first non-empty class starting at rr_ptr, wrapping modulo 4.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pop is decided in the same cycle so the FIFO's empty flag is current on the next scan;
  // an overflowing push also suppresses any new pop so no extra word is lost.
  assign pop_en = (state == S_ACTIVE) && !almost_full_out && grant_found && !overflow;
  assign pop    = pop_en ? 4'(4'b0001 << grant_idx) : 4'b0000;

  // Select the registered read data of the class granted in the previous cycle.
  always_comb begin
    data_sel = data_in4[TAMANO_DATOS-3:0];
    case (push_idx)
      2'd0: data_sel = data_in4[TAMANO_DATOS-3:0];
      2'd1: data_sel = data_in5[TAMANO_DATOS-3:0];
      2'd2: data_sel = data_in6[TAMANO_DATOS-3:0];
      2'd3: data_sel = data_in7[TAMANO_DATOS-3:0];
      default: data_sel = data_in4[TAMANO_DATOS-3:0];
    endcase
  end

  assign fresh_word = {push_idx, data_sel};
  assign data_out   = push ? fresh_word : data_hold;

  // Control FSM, round-robin pointer, push pipeline stage and threshold latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RESET;
      rr_ptr       <= 2'd0;
      push         <= 1'b0;
      push_idx     <= 2'd0;
      data_hold    <= '0;
      umbral_L_out <= '0;
      umbral_H_out <= '0;
      error_out    <= 1'b0;
    end else begin
      push <= pop_en;
      if (pop_en) begin
        push_idx <= grant_idx;
        rr_ptr   <= grant_idx + 2'd1;
      end
      if (push) begin
        data_hold <= fresh_word;
      end
      case (state)
        S_RESET: state <= S_INIT;
        S_INIT: begin
          umbral_L_out <= umbral_L;
          umbral_H_out <= umbral_H;
          if (!init) state <= S_IDLE;
        end
        S_IDLE: begin
          if (overflow) begin
            state     <= S_ERROR;
            error_out <= 1'b1;
          end else if (init) begin
            state <= S_INIT;
          end else if (!(&empty)) begin
            state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (overflow) begin
            state     <= S_ERROR;
            error_out <= 1'b1;
          end else if ((&empty) && !push) begin
            state <= S_IDLE;
          end
        end
        S_ERROR: error_out <= 1'b1;
        default: state <= S_RESET;
      endcase
    end
  end

  // Per-class and total push counters plus the one-cycle counter read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
      cnt_total      <= '0;
      contador       <= '0;
      valid_contador <= 1'b0;
    end else begin
      if (push) begin
        cnt[push_idx] <= cnt[push_idx] + CNT_ONE;
        cnt_total     <= cnt_total + CNT_ONE;
      end
      valid_contador <= req;
      if (req) begin
        if (!idx[2]) contador <= cnt[idx[1:0]];
        else if (idx[1:0] == 2'd0) contador <= cnt_total;
        else contador <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_arbitro_tx.sv
// tb/tb_pcie_arbitro_tx.sv - directed self-checking bench for pcie_arbitro_tx
module tb_pcie_arbitro_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic [7:0]  umbral_L = 8'd0;
  logic [7:0]  umbral_H = 8'd0;
  logic [11:0] din0 = 12'd0, din1 = 12'd0, din2 = 12'd0, din3 = 12'd0;
  logic [3:0]  empty = 4'hF;
  logic        almost_full_out = 1'b0;
  logic        full_out = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  idx = 3'd0;
  logic [3:0]  pop;
  logic        push;
  logic [11:0] data_out;
  logic [7:0]  umbral_L_out, umbral_H_out;
  logic [2:0]  estado;
  logic        error_out;
  logic [4:0]  contador;
  logic        valid_contador;

  logic [11:0] q0[$], q1[$], q2[$], q3[$];
  int exp_cnt [4];
  int exp_total = 0;
  int checks = 0;
  int failures = 0;

  pcie_arbitro_tx dut (
    .clk(clk), .reset(reset), .init(init), .umbral_L(umbral_L), .umbral_H(umbral_H),
    .data_in4(din0), .data_in5(din1), .data_in6(din2), .data_in7(din3),
    .empty(empty), .almost_full_out(almost_full_out), .full_out(full_out),
    .req(req), .idx(idx), .pop(pop), .push(push), .data_out(data_out),
    .umbral_L_out(umbral_L_out), .umbral_H_out(umbral_H_out), .estado(estado),
    .error_out(error_out), .contador(contador), .valid_contador(valid_contador)
  );

  always #5 clk = ~clk;

  // Class FIFO models: registered read data, empty flag refreshed after each edge.
  always @(posedge clk) begin
    if (pop[0] && q0.size() > 0) din0 <= q0.pop_front();
    if (pop[1] && q1.size() > 0) din1 <= q1.pop_front();
    if (pop[2] && q2.size() > 0) din2 <= q2.pop_front();
    if (pop[3] && q3.size() > 0) din3 <= q3.pop_front();
    empty <= {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
  end

  task automatic load(input int cls, input logic [11:0] w);
    case (cls)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    exp_cnt[cls] = exp_cnt[cls] + 1;
    exp_total = exp_total + 1;
  endtask

  task automatic wait_pop(input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      if (pop != 4'b0000) ok = 1'b1;
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      if (estado == s) ok = 1'b1;
      n++;
    end
  endtask

  task automatic test_reset;
    logic [42:0] all_out;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    all_out = {pop, push, data_out, umbral_L_out, umbral_H_out, estado, error_out, contador, valid_contador};
    checks++;
    if (all_out !== 43'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    reset = 1'b0; init = 1'b1; umbral_L = 8'd2; umbral_H = 8'd6;
    @(negedge clk);
    checks++;
    if (estado !== 3'd1) begin failures++; $display("FAIL reset_to_init: got %0d expected 1", estado); end
    @(negedge clk);
    checks++;
    if (umbral_L_out !== 8'd2 || umbral_H_out !== 8'd6 || estado !== 3'd1 || pop !== 4'd0) begin
      failures++; $display("FAIL init_latch: got L=%0d H=%0d st=%0d pop=%b expected L=2 H=6 st=1 pop=0000", umbral_L_out, umbral_H_out, estado, pop);
    end
    init = 1'b0;
    @(negedge clk);
    checks++;
    if (estado !== 3'd2) begin failures++; $display("FAIL init_to_idle: got %0d expected 2", estado); end
  endtask

  task automatic test_fairness;
    bit ok;
    int c, r;
    logic [11:0] exp_w;
    for (int cl = 0; cl < 4; cl++)
      for (int rr = 0; rr < 3; rr++) load(cl, 12'(12'hC00 | (cl * 16 + rr)));
    wait_pop(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fair_start: got no pop expected pop within 10 cycles"); end
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (j < 12 && pop !== 4'(1 << (j % 4))) begin
        failures++; $display("FAIL fair_pop%0d: got %b expected %b", j, pop, 4'(1 << (j % 4)));
      end else if (j == 12 && pop !== 4'b0000) begin
        failures++; $display("FAIL fair_pop_end: got %b expected 0000", pop);
      end
      if (j > 0) begin
        c = (j - 1) % 4;
        r = (j - 1) / 4;
        exp_w = {2'(c), 10'(c * 16 + r)};
        checks++;
        if (push !== 1'b1 || data_out !== exp_w) begin
          failures++; $display("FAIL fair_push%0d: got push=%b data=%h expected push=1 data=%h", j - 1, push, data_out, exp_w);
        end
      end
    end
    wait_state(3'd2, 10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fair_idle: got estado=%0d expected 2", estado); end
  endtask

  task automatic test_retag;
    bit ok;
    load(2, 12'hFFF);
    wait_pop(10, ok);
    checks++;
    if (!ok || pop !== 4'b0100) begin failures++; $display("FAIL retag_pop: got %b expected 0100", pop); end
    @(negedge clk);
    checks++;
    if (push !== 1'b1 || data_out !== 12'hBFF) begin
      failures++; $display("FAIL retag_push: got push=%b data=%h expected push=1 data=bff", push, data_out);
    end
    wait_state(3'd2, 10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL retag_idle: got estado=%0d expected 2", estado); end
  endtask

  task automatic test_backpressure;
    bit ok;
    for (int k = 0; k < 8; k++) load(0, 12'(12'h800 | k));
    wait_pop(10, ok);
    checks++;
    if (!ok || pop !== 4'b0001) begin failures++; $display("FAIL bp_first_pop: got %b expected 0001", pop); end
    @(negedge clk);
    checks++;
    if (push !== 1'b1 || data_out !== 12'h000) begin
      failures++; $display("FAIL bp_inflight: got push=%b data=%h expected push=1 data=000", push, data_out);
    end
    almost_full_out = 1'b1;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      checks++;
      if (push !== 1'b0 || pop !== 4'b0000 || data_out !== 12'h000) begin
        failures++; $display("FAIL bp_hold%0d: got push=%b pop=%b data=%h expected push=0 pop=0000 data=000", w, push, pop, data_out);
      end
    end
    almost_full_out = 1'b0;
    #1;
    checks++;
    if (pop !== 4'b0001) begin failures++; $display("FAIL bp_resume_pop: got %b expected 0001", pop); end
    @(negedge clk);
    checks++;
    if (push !== 1'b1 || data_out !== 12'h001) begin
      failures++; $display("FAIL bp_resume_push: got push=%b data=%h expected push=1 data=001", push, data_out);
    end
    wait_state(3'd2, 30, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_idle: got estado=%0d expected 2", estado); end
  endtask

  task automatic test_counters;
    bit ok;
    int pre;
    int exp_rd;
    pre = exp_cnt[1] % 32;
    for (int k = 0; k < 33; k++) load(1, 12'(k));
    wait_pop(10, ok);
    checks++;
    if (!ok || pop !== 4'b0010) begin failures++; $display("FAIL cnt_stream_pop: got %b expected 0010", pop); end
    @(negedge clk);
    checks++;
    if (push !== 1'b1) begin failures++; $display("FAIL cnt_stream_push: got %b expected 1", push); end
    req = 1'b1; idx = 3'd1;
    @(negedge clk);
    checks++;
    if (valid_contador !== 1'b1 || contador !== 5'(pre)) begin
      failures++; $display("FAIL cnt_same_cycle: got v=%b cnt=%0d expected v=1 cnt=%0d", valid_contador, contador, pre);
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_contador !== 1'b0 || contador !== 5'(pre)) begin
      failures++; $display("FAIL cnt_hold: got v=%b cnt=%0d expected v=0 cnt=%0d", valid_contador, contador, pre);
    end
    wait_state(3'd2, 80, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL cnt_idle: got estado=%0d expected 2", estado); end
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; idx = 3'(i);
      @(negedge clk);
      exp_rd = (i < 4) ? exp_cnt[i] % 32 : (i == 4) ? exp_total % 32 : 0;
      checks++;
      if (valid_contador !== 1'b1 || contador !== 5'(exp_rd)) begin
        failures++; $display("FAIL cnt_read_idx%0d: got v=%b cnt=%0d expected v=1 cnt=%0d", i, valid_contador, contador, exp_rd);
      end
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_contador !== 1'b0) begin failures++; $display("FAIL cnt_valid_low: got %b expected 0", valid_contador); end
  endtask

  task automatic test_overflow;
    bit ok;
    for (int k = 0; k < 4; k++) load(3, 12'(12'h300 | k));
    wait_pop(10, ok);
    checks++;
    if (!ok || pop !== 4'b1000) begin failures++; $display("FAIL ovf_pop: got %b expected 1000", pop); end
    @(negedge clk);
    checks++;
    if (push !== 1'b1) begin failures++; $display("FAIL ovf_push: got %b expected 1", push); end
    full_out = 1'b1;
    @(negedge clk);
    full_out = 1'b0;
    checks++;
    if (estado !== 3'd4 || error_out !== 1'b1 || pop !== 4'b0000 || push !== 1'b0) begin
      failures++; $display("FAIL ovf_enter: got st=%0d err=%b pop=%b push=%b expected st=4 err=1 pop=0000 push=0", estado, error_out, pop, push);
    end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checks++;
      if (estado !== 3'd4 || error_out !== 1'b1 || pop !== 4'b0000) begin
        failures++; $display("FAIL ovf_sticky%0d: got st=%0d err=%b pop=%b expected st=4 err=1 pop=0000", w, estado, error_out, pop);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (estado !== 3'd0 || error_out !== 1'b0 || push !== 1'b0) begin
      failures++; $display("FAIL ovf_reset: got st=%0d err=%b push=%b expected st=0 err=0 push=0", estado, error_out, push);
    end
    reset = 1'b0;
    q3.delete();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    test_reset;
    test_fairness;
    test_retag;
    test_backpressure;
    test_counters;
    test_overflow;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
